// File: rtl/cp0_unit_if.sv
// M-stage to CP0 connection bundle: mfc0/mtc0 access, exception inputs,
// external interrupt lines, and the flush request and read-back outputs.
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] PC;
  logic [4:0]  ExcCode;
  logic        isdb;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] DOut;
  logic [31:0] EPC_out;

  // Pipeline side: drives the M-stage request, consumes CP0 results.
  modport master (
    output A1, A2, DIn, WE, EXLClr, PC, ExcCode, isdb, HWInt,
    input  IntReq, DOut, EPC_out
  );

  // CP0 side.
  modport slave (
    input  A1, A2, DIn, WE, EXLClr, PC, ExcCode, isdb, HWInt,
    output IntReq, DOut, EPC_out
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PrID registers, interrupt/exception
// detection and single-cycle exception entry / eret handling.
module cp0_unit (
  input  logic         clk,
  input  logic         reset,
  cp0_unit_if.slave    bus
);

  localparam logic [4:0]  REG_SR    = 5'd12;
  localparam logic [4:0]  REG_CAUSE = 5'd13;
  localparam logic [4:0]  REG_EPC   = 5'd14;
  localparam logic [4:0]  REG_PRID  = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h0000_2021;

  // SR fields
  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  // Cause fields
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  // EPC word address (low two bits always zero)
  logic [29:0] epc_r;

  logic [4:0]  exc_code_eff_s;
  logic        int_pend_s;
  logic        exc_pend_s;
  logic        int_req_s;
  logic [31:0] epc_src_s;
  logic        wr_sr_s;
  logic        wr_epc_s;
  logic [31:0] dout_s;

  // Exception code is masked while reset is high so no request leaks out.
  assign exc_code_eff_s = reset ? 5'd0 : bus.ExcCode;
  assign int_pend_s     = (|(bus.HWInt & im_r)) & ie_r & ~exl_r;
  assign exc_pend_s     = (exc_code_eff_s != 5'd0) & ~exl_r;
  assign int_req_s      = ~reset & (int_pend_s | exc_pend_s);

  // A delay-slot instruction restarts at its branch; subtraction wraps mod 2^32.
  assign epc_src_s = bus.isdb ? (bus.PC - 32'd4) : bus.PC;

  assign wr_sr_s  = bus.WE & (bus.A2 == REG_SR);
  assign wr_epc_s = bus.WE & (bus.A2 == REG_EPC);

  // Register update: reset, then exception entry, then eret / mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_r       <= 6'd0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_r       <= 6'd0;
      exc_code_r <= 5'd0;
      epc_r      <= 30'd0;
    end else begin
      ip_r <= bus.HWInt;
      if (int_req_s) begin
        // The M-stage instruction is cancelled, so WE/EXLClr are ignored.
        exl_r      <= 1'b1;
        exc_code_r <= int_pend_s ? 5'd0 : bus.ExcCode;
        bd_r       <= bus.isdb;
        epc_r      <= epc_src_s[31:2];
      end else begin
        if (bus.EXLClr) begin
          exl_r <= 1'b0;
        end
        // Placed after the eret clear so an mtc0 to SR wins for EXL.
        if (wr_sr_s) begin
          im_r  <= bus.DIn[15:10];
          exl_r <= bus.DIn[1];
          ie_r  <= bus.DIn[0];
        end
        if (wr_epc_s) begin
          epc_r <= bus.DIn[31:2];
        end
      end
    end
  end

  // mfc0 read mux over the current register state.
  always_comb begin
    dout_s = 32'd0;
    case (bus.A1)
      REG_SR:    dout_s = {16'd0, im_r, 8'd0, exl_r, ie_r};
      REG_CAUSE: dout_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      REG_EPC:   dout_s = {epc_r, 2'b00};
      REG_PRID:  dout_s = PRID_VAL;
      default:   dout_s = 32'd0;
    endcase
  end

  assign bus.IntReq  = int_req_s;
  assign bus.DOut    = dout_s;
  // Bypass so an eret directly behind an mtc0 EPC sees the new value.
  assign bus.EPC_out = wr_epc_s ? {bus.DIn[31:2], 2'b00} : {epc_r, 2'b00};

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized
// traffic compared against a word-level reference model.
module tb_cp0_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: whole architectural register words.
  logic [31:0] sr_m;
  logic [31:0] cause_m;
  logic [31:0] epc_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (a)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
      5'd15:   return 32'h0000_2021;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int_pend();
    return !reset && ((bus.HWInt & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
  endfunction

  function automatic logic m_exc_pend();
    return !reset && (bus.ExcCode != 5'd0) && !sr_m[1];
  endfunction

  task automatic idle();
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0;
    bus.EXLClr = 1'b0; bus.PC = 32'd0; bus.ExcCode = 5'd0; bus.isdb = 1'b0;
    bus.HWInt = 6'd0;
  endtask

  // Check combinational outputs against the model, then advance one edge.
  task automatic step();
    logic ireq, ipend;
    #1;
    ipend = m_int_pend();
    ireq  = ipend | m_exc_pend();
    check_eq("IntReq", {31'd0, bus.IntReq}, {31'd0, ireq});
    check_eq("DOut", bus.DOut, m_dout(bus.A1));
    check_eq("EPC_out", bus.EPC_out,
             (bus.WE && bus.A2 == 5'd14) ? (bus.DIn & 32'hFFFF_FFFC) : epc_m);
    if (reset) begin
      sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
    end else if (ireq) begin
      sr_m = sr_m | 32'h2;
      cause_m = ({27'd0, ipend ? 5'd0 : bus.ExcCode} << 2)
              | ({26'd0, bus.HWInt} << 10)
              | ({31'd0, bus.isdb} << 31);
      epc_m = (bus.isdb ? bus.PC - 32'd4 : bus.PC) & 32'hFFFF_FFFC;
    end else begin
      cause_m = (cause_m & ~32'h0000_FC00) | ({26'd0, bus.HWInt} << 10);
      if (bus.EXLClr) sr_m = sr_m & ~32'h2;
      if (bus.WE && bus.A2 == 5'd12) sr_m = bus.DIn & 32'h0000_FC03;
      if (bus.WE && bus.A2 == 5'd14) epc_m = bus.DIn & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.A1 = a;
    #1;
    check_eq(tag, bus.DOut, exp);
  endtask

  initial begin
    sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
    reset = 1'b1;
    idle();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state
    peek(5'd15, "prid", 32'h0000_2021);
    peek(5'd12, "sr_rst", 32'd0);
    peek(5'd13, "cause_rst", 32'd0);
    peek(5'd14, "epc_rst", 32'd0);
    check_eq("intreq_rst", {31'd0, bus.IntReq}, 32'd0);

    // mtc0 SR then a level interrupt
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    step();
    bus.WE = 1'b0; bus.HWInt = 6'b000001;
    #1 check_eq("int_req", {31'd0, bus.IntReq}, 32'd1);
    step();
    peek(5'd12, "sr_exl", 32'h0000_0403);
    peek(5'd13, "cause_int", 32'h0000_0400);
    check_eq("int_masked_exl", {31'd0, bus.IntReq}, 32'd0);

    // Exception from a delay slot
    bus.EXLClr = 1'b1; bus.HWInt = 6'd0;
    step();
    bus.EXLClr = 1'b0; bus.ExcCode = 5'd4; bus.PC = 32'h0000_3008; bus.isdb = 1'b1;
    #1 check_eq("exc_req", {31'd0, bus.IntReq}, 32'd1);
    step();
    bus.ExcCode = 5'd0; bus.isdb = 1'b0;
    peek(5'd14, "epc_bd", 32'h0000_3004);
    peek(5'd13, "cause_bd", 32'h8000_0010);

    // Masked while EXL, then eret clears EXL
    bus.ExcCode = 5'd10;
    #1 check_eq("exc_masked", {31'd0, bus.IntReq}, 32'd0);
    step();
    bus.ExcCode = 5'd0; bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;
    peek(5'd12, "sr_eret", 32'h0000_0401);

    // Exception cancels a same-cycle mtc0 EPC
    bus.ExcCode = 5'd12; bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5000;
    bus.PC = 32'h0000_4000;
    #1 check_eq("exc_vs_mtc0", {31'd0, bus.IntReq}, 32'd1);
    step();
    bus.ExcCode = 5'd0; bus.WE = 1'b0;
    peek(5'd14, "epc_cancel", 32'h0000_4000);
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0; bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3003;
    #1 check_eq("epc_bypass", bus.EPC_out, 32'h0000_3000);
    step();
    bus.WE = 1'b0;
    peek(5'd14, "epc_write", 32'h0000_3000);

    // mtc0 SR wins over eret for EXL
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403; bus.EXLClr = 1'b1;
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b0;
    peek(5'd12, "sr_mtc0_wins", 32'h0000_0403);
    bus.EXLClr = 1'b1;
    step();
    bus.EXLClr = 1'b0;

    // Interrupt priority over exception
    bus.HWInt = 6'b000001; bus.ExcCode = 5'd4; bus.PC = 32'h0000_2000;
    step();
    bus.ExcCode = 5'd0;
    peek(5'd13, "int_prio", 32'h0000_0400);

    // Reset while EXL, with lines and exception active
    reset = 1'b1; bus.HWInt = 6'h3F; bus.ExcCode = 5'd4;
    #1 check_eq("intreq_in_reset", {31'd0, bus.IntReq}, 32'd0);
    step();
    reset = 1'b0; bus.ExcCode = 5'd0; bus.HWInt = 6'd0;
    peek(5'd12, "sr_rst2", 32'd0);
    peek(5'd13, "cause_rst2", 32'd0);
    peek(5'd14, "epc_rst2", 32'd0);

    // PC-4 wraps
    bus.ExcCode = 5'd1; bus.PC = 32'd0; bus.isdb = 1'b1;
    step();
    bus.ExcCode = 5'd0; bus.isdb = 1'b0;
    peek(5'd14, "epc_wrap", 32'hFFFF_FFFC);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.A1      = 5'd11 + 5'($urandom_range(0, 5));
      bus.A2      = 5'd11 + 5'($urandom_range(0, 4));
      bus.DIn     = $urandom;
      bus.WE      = ($urandom_range(0, 2) == 0);
      bus.EXLClr  = ($urandom_range(0, 3) == 0);
      bus.PC      = $urandom & 32'hFFFF_FFFC;
      bus.ExcCode = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.isdb    = 1'($urandom_range(0, 1));
      bus.HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      reset       = ($urandom_range(0, 60) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
